// File: rtl/log2_pkg.sv
// Shared definitions for the log2_seq engine: FSM states, byte width and
// the result-width helper.
package log2_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  function automatic int log2_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/log2_seq_byte_pow8.sv
// Highest-set-bit encoder for one byte: pow is the index of the MSB that is
// set, nz flags a nonzero byte (pow is 0 when the byte is 0).
module byte_pow8 (
  input  logic [7:0] byte_in,
  output logic [2:0] pow,
  output logic       nz
);

  always_comb begin
    pow = 3'd0;
    nz  = |byte_in;
    // Ascending scan so the last hit, i.e. the most significant set bit, wins.
    for (int i = 0; i < 8; i++) begin
      if (byte_in[i]) pow = 3'(i);
    end
  end

endmodule

// File: rtl/log2_seq.sv
// Sequential floor(log2) engine scanning one byte per cycle from the top.
// Define LOG2_SEQ_POW2_EN to add the out_pow2 (single set bit) result flag.
module log2_seq
  import log2_pkg::*;
#(
  parameter  int WIDTH  = 32,
  localparam int NBYTES = WIDTH / BYTE_W,
  localparam int LW     = log2_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    out_log,
`ifdef LOG2_SEQ_POW2_EN
  output logic             out_pow2,
`endif
  output logic             out_zero
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_q, op_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     log_q, log_d;
  logic              zero_q, zero_d;
`ifdef LOG2_SEQ_POW2_EN
  logic              pow2_q, pow2_d;
`endif

  logic [BYTE_W-1:0] byte_arr [NBYTES];
  logic [BYTE_W-1:0] cur_byte;
  logic [2:0]        pow;
  logic              nz;

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
    assign byte_arr[gi] = op_q[gi*BYTE_W +: BYTE_W];
  end

  assign cur_byte = byte_arr[idx_q];

  byte_pow8 u_enc (
    .byte_in (cur_byte),
    .pow     (pow),
    .nz      (nz)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    log_d   = log_q;
    zero_d  = zero_q;
`ifdef LOG2_SEQ_POW2_EN
    pow2_d  = pow2_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          idx_d   = IW'(NBYTES - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (nz) begin
          log_d   = (LW'(idx_q) << 3) + LW'(pow);
          zero_d  = 1'b0;
`ifdef LOG2_SEQ_POW2_EN
          pow2_d  = ((op_q & (op_q - WIDTH'(1))) == '0);
`endif
          state_d = DONE;
        end else if (idx_q == '0) begin
          log_d   = '0;
          zero_d  = 1'b1;
`ifdef LOG2_SEQ_POW2_EN
          pow2_d  = 1'b0;
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      log_q   <= '0;
      zero_q  <= 1'b0;
`ifdef LOG2_SEQ_POW2_EN
      pow2_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      log_q   <= log_d;
      zero_q  <= zero_d;
`ifdef LOG2_SEQ_POW2_EN
      pow2_q  <= pow2_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_log   = log_q;
  assign out_zero  = zero_q;
`ifdef LOG2_SEQ_POW2_EN
  assign out_pow2  = pow2_q;
`endif

endmodule

// File: tb/tb_log2_seq.sv
// Directed self-checking bench for log2_seq at WIDTH=32 with hand-computed
// results, latencies, backpressure and mid-scan reset.
module tb_log2_seq;

  localparam int WIDTH = 32;
  localparam int LW    = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    out_log;
  logic             out_zero;
`ifdef LOG2_SEQ_POW2_EN
  logic             out_pow2;
`endif

  int total = 0;
  int bad   = 0;

  log2_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_log   (out_log),
`ifdef LOG2_SEQ_POW2_EN
    .out_pow2  (out_pow2),
`endif
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] data,
                        input int exp_log, input bit exp_zero, input int exp_lat,
                        input bit exp_pow2);
    int lat;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    wait_valid(lat);
    check({tag, ".lat"},  64'(lat), 64'(exp_lat));
    check({tag, ".log"},  64'(out_log), 64'(exp_log));
    check({tag, ".zero"}, 64'(out_zero), 64'(exp_zero));
`ifdef LOG2_SEQ_POW2_EN
    check({tag, ".pow2"}, 64'(out_pow2), 64'(exp_pow2));
`else
    if (exp_pow2) begin end
`endif
    tick();
    check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_log",   64'(out_log),   64'd0);
    check("rst.out_zero",  64'(out_zero),  64'd0);
    rst_n = 1'b1;
    tick();

    run_op("msb",    32'h8000_0000, 31, 1'b0, 1, 1'b1);
    run_op("x2c00",  32'h0000_2C00, 13, 1'b0, 3, 1'b0);
    run_op("one",    32'h0000_0001,  0, 1'b0, 4, 1'b1);
    run_op("x10000", 32'h0001_0000, 16, 1'b0, 2, 1'b1);
    run_op("zero",   32'h0000_0000,  0, 1'b1, 4, 1'b0);
    run_op("ffffff", 32'h00FF_FFFF, 23, 1'b0, 2, 1'b0);

    // Backpressure: result must hold while the next operand waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_00FF;
    tick();
    in_data = 32'h0000_1234;
    wait_valid(lat);
    check("bp.lat", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.hold%0d.valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp.hold%0d.log", i),   64'(out_log),   64'd7);
      check($sformatf("bp.hold%0d.ready", i), 64'(in_ready),  64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp.after_hs.valid", 64'(out_valid), 64'd0);
    check("bp.after_hs.ready", 64'(in_ready),  64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    check("bp.next.ready", 64'(in_ready), 64'd0);
    wait_valid(lat);
    check("bp.next.lat", 64'(lat), 64'd3);
    check("bp.next.log", 64'(out_log), 64'd12);
    tick();

    // Reset in the middle of a scan discards the operand.
    in_valid = 1'b1;
    in_data  = 32'h0000_0010;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", 64'(out_valid), 64'd0);
    check("mrst.in_ready",  64'(in_ready),  64'd1);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mrst.no_result", 64'(seen), 64'd0);
    run_op("after_rst", 32'h0000_0004, 2, 1'b0, 4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
